data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_if.sv | 32 +++
 rtl/load_align.sv | 32 +++
 rtl/data_mem_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory controller.
//   SZ_*              : access size encodings carried on REQ_SIZE
//   MAX_READ_LATENCY  : deepest supported response pipeline
//   mem_state_e       : controller FSM state (clear sweep / normal operation)
package data_mem_pkg;

  localparam int MAX_READ_LATENCY = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus of the data memory controller.
//   Request : REQ_VALID/REQ_READY handshake with REQ_WE, REQ_ADDR, REQ_SIZE,
//             REQ_UNSIGNED, REQ_WDATA.
//   Response: RSP_VALID strobe with RSP_RDATA and RSP_ERR (no backpressure).
//   Status  : INIT_DONE.
// Handshake: a request transfers on any rising CLK edge where REQ_VALID and
// REQ_READY are both high; the master must hold the request fields stable
// while REQ_VALID is high. RSP_VALID is a one-cycle strobe per accepted
// request, in acceptance order, and RSP_RDATA/RSP_ERR are zero outside it.
interface data_mem_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        INIT_DONE;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_SIZE, REQ_UNSIGNED, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, INIT_DONE
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_SIZE, REQ_UNSIGNED, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, INIT_DONE
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/half lane of a 32-bit word,
// moves it to bit 0 and sign- or zero-extends it. Word accesses pass through.
//   word        : raw memory word
//   lane        : byte address bits [1:0]
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   result      : aligned, extended load value
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    result = word;
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: result = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte/half/word access, misalignment and range
// checking, a power-on clear sweep and a fixed-latency response pipeline.
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : data_mem_if slave (request, response, INIT_DONE)
//   dbg_state : current FSM state
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  data_mem_if.slave  bus,
  output mem_state_e dbg_state
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                       (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  logic [31:0] mem [DEPTH_WORDS];

  mem_state_e  state;
  logic [AW-1:0] cnt;
  logic        ready_q;
  logic        done_q;

  assign bus.REQ_READY = ready_q;
  assign bus.INIT_DONE = done_q;
  assign dbg_state     = state;

  // ---------------- request decode ----------------
  logic          accept;
  logic [AW-1:0] word_idx;
  logic          range_err;
  logic          size_err;
  logic          req_err;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic          wr_en;

  // Reset has priority over any request presented on the same edge.
  assign accept    = bus.REQ_VALID && ready_q && !RST;
  assign word_idx  = bus.REQ_ADDR[AW+1:2];
  assign range_err = |bus.REQ_ADDR[31:AW+2];

  always_comb begin
    size_err  = 1'b0;
    be        = 4'b0000;
    wdata_rep = bus.REQ_WDATA;
    case (bus.REQ_SIZE)
      SZ_BYTE: begin
        be        = 4'b0001 << bus.REQ_ADDR[1:0];
        wdata_rep = {4{bus.REQ_WDATA[7:0]}};
      end
      SZ_HALF: begin
        size_err  = bus.REQ_ADDR[0];
        be        = bus.REQ_ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.REQ_WDATA[15:0]}};
      end
      SZ_WORD: begin
        size_err  = |bus.REQ_ADDR[1:0];
        be        = 4'b1111;
      end
      default: size_err = 1'b1;
    endcase
  end

  assign req_err = size_err || range_err;
  assign wr_en   = accept && bus.REQ_WE && !req_err;

  // ---------------- FSM: clear sweep then run ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH_WORDS - 1)) begin
        state   <= ST_RUN;
        ready_q <= 1'b1;
        done_q  <= 1'b1;
      end
    end
  end

  // ---------------- memory array ----------------
  // The sweep owns the write port during INIT; requests are never accepted then.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // ---------------- load path ----------------
  logic [31:0] rd_word;
  logic [31:0] rd_aligned;

  // Asynchronous read sampled at the accept edge: sees pre-store contents.
  assign rd_word = mem[word_idx];

  load_align u_load_align (
    .word        (rd_word),
    .lane        (bus.REQ_ADDR[1:0]),
    .size        (bus.REQ_SIZE),
    .is_unsigned (bus.REQ_UNSIGNED),
    .result      (rd_aligned)
  );

  // ---------------- response pipeline ----------------
  // Stage 0 is loaded at the accept edge; data and error are forced to zero
  // for idle slots so every stage already satisfies the zero-when-idle rule.
  logic [LAT-1:0] pv;
  logic [LAT-1:0] pe;
  logic [31:0]    pd [LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && req_err;
      pd[0] <= (accept && !bus.REQ_WE && !req_err) ? rd_aligned : 32'h0;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.RSP_VALID = pv[LAT-1];
  assign bus.RSP_ERR   = pe[LAT-1];
  assign bus.RSP_RDATA = pd[LAT-1];

endmodule
